// File: rtl/semafor_pkg.sv
// semafor_pkg
// Shared definitions for the traffic-light controller and the direction
// modules that listen to its phase broadcast.
//   phase_t        : 3-bit phase code driven on stare_semafor
//   PH_*           : phase code constants (101 and 110 are never driven)
//   cnt_width()    : minimum counter width able to hold 0..n-1 (at least 1 bit)
//   dir_phase()    : phase code of direction index 0..3 (EST, SUD, VEST, NORD)
package semafor_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_ALL_RED     = 3'b000;
  localparam phase_t PH_EST         = 3'b001;
  localparam phase_t PH_SUD         = 3'b010;
  localparam phase_t PH_VEST        = 3'b011;
  localparam phase_t PH_NORD        = 3'b100;
  localparam phase_t PH_INTERMITENT = 3'b111;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic phase_t dir_phase(input logic [1:0] idx);
    case (idx)
      2'd0:    return PH_EST;
      2'd1:    return PH_SUD;
      2'd2:    return PH_VEST;
      default: return PH_NORD;
    endcase
  endfunction

endpackage

// File: rtl/semafor_if.sv
// semafor_if
// Broadcast bus between the controller and the four direction modules.
//   stare_semafor : phase code from the controller
//   clk_div       : active-low tick, low one clk cycle per prescaler period
//   clk_div_int   : flashing-amber enable, meaningful only in PH_INTERMITENT
//   ready_E/S/V/N : phase-done pulses from each direction module
// Modports: master = controller side, slave = direction module side.
interface semafor_if;
  import semafor_pkg::*;

  phase_t stare_semafor;
  logic   clk_div;
  logic   clk_div_int;
  logic   ready_E;
  logic   ready_S;
  logic   ready_V;
  logic   ready_N;

  modport master (
    output stare_semafor, clk_div, clk_div_int,
    input  ready_E, ready_S, ready_V, ready_N
  );

  modport slave (
    input  stare_semafor, clk_div, clk_div_int,
    output ready_E, ready_S, ready_V, ready_N
  );

endinterface

// File: rtl/semafor_prescaler.sv
// semafor_prescaler
// Free-running divider that produces the system tick.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   clk_div : low exactly one clk cycle every DIV_CYC cycles (the tick)
module semafor_prescaler
  import semafor_pkg::*;
#(
  parameter int DIV_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic clk_div
);

  localparam int CNT_W = cnt_width(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV_CYC-1 continuously and wrap; the count is never stopped,
  // so the tick keeps running in every controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decoded straight from the count register, so it is glitch-free and
  // reads 1 while reset holds the count at zero.
  assign clk_div = (cnt != CNT_LAST);

endmodule

// File: rtl/semafor_ctrl.sv
// semafor_ctrl
// Intersection phase sequencer: all-red clearance between greens, greens in
// fixed order EST->SUD->VEST->NORD, per-green watchdog, and a flashing-amber
// mode for night operation or after a watchdog fault.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   mod_noapte : night-mode request (level)
//   bus        : semafor_if master (phase code, tick, blink enable, readies)
//   fault      : sticky watchdog flag, cleared only by rst
module semafor_ctrl
  import semafor_pkg::*;
#(
  parameter int DIV_CYC    = 16,
  parameter int T_CLEAR    = 2,
  parameter int T_TIMEOUT  = 40,
  parameter int BLINK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mod_noapte,
  semafor_if.master  bus,
  output logic       fault
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_GREEN = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;

  localparam int CLR_W = cnt_width(T_CLEAR);
  localparam int WD_W  = cnt_width(T_TIMEOUT);
  localparam int BL_W  = cnt_width(BLINK_HALF);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(T_CLEAR - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(T_TIMEOUT - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_HALF - 1);

  logic             clk_div_n;
  logic             tick;
  logic [1:0]       state;
  logic [1:0]       dir_idx;
  logic             ready_match;
  phase_t           phase_q;
  logic             blink_q;
  logic [CLR_W-1:0] clear_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [BL_W-1:0]  blink_cnt;

  semafor_prescaler #(
    .DIV_CYC (DIV_CYC)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div_n)
  );

  assign tick              = ~clk_div_n;
  assign bus.clk_div       = clk_div_n;
  assign bus.stare_semafor = phase_q;
  assign bus.clk_div_int   = blink_q;

  // Only the ready of the direction currently (or next) in green counts;
  // the other three are simply not looked at.
  always_comb begin
    ready_match = 1'b0;
    case (dir_idx)
      2'd0:    ready_match = bus.ready_E;
      2'd1:    ready_match = bus.ready_S;
      2'd2:    ready_match = bus.ready_V;
      default: ready_match = bus.ready_N;
    endcase
  end

  // Phase sequencer. Outputs are registered next to the state so the phase
  // code changes in the cycle after the condition that caused the move.
  // dir_idx always names the direction of the pending or current green and
  // only advances when that green finishes on its own ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      phase_q   <= PH_ALL_RED;
      blink_q   <= 1'b0;
      fault     <= 1'b0;
      dir_idx   <= 2'd0;
      clear_cnt <= '0;
      wd_cnt    <= '0;
      blink_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Clearance is a phase boundary, so night mode may take over here.
          if (mod_noapte) begin
            state     <= ST_FLASH;
            phase_q   <= PH_INTERMITENT;
            blink_q   <= 1'b1;
            blink_cnt <= '0;
          end else if (tick) begin
            if (clear_cnt == CLR_LAST) begin
              state   <= ST_GREEN;
              phase_q <= dir_phase(dir_idx);
              wd_cnt  <= '0;
            end else begin
              clear_cnt <= clear_cnt + 1'b1;
            end
          end
        end

        ST_GREEN: begin
          // Ready is checked first so it beats a coincident watchdog expiry.
          if (ready_match) begin
            dir_idx <= dir_idx + 1'b1;
            if (mod_noapte) begin
              state     <= ST_FLASH;
              phase_q   <= PH_INTERMITENT;
              blink_q   <= 1'b1;
              blink_cnt <= '0;
            end else begin
              state     <= ST_CLEAR;
              phase_q   <= PH_ALL_RED;
              clear_cnt <= '0;
            end
          end else if (tick) begin
            if (wd_cnt == WD_LAST) begin
              state     <= ST_FLASH;
              phase_q   <= PH_INTERMITENT;
              blink_q   <= 1'b1;
              blink_cnt <= '0;
              fault     <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end

        ST_FLASH: begin
          // A latched fault pins the block here until reset.
          if (!mod_noapte && !fault) begin
            state     <= ST_CLEAR;
            phase_q   <= PH_ALL_RED;
            blink_q   <= 1'b0;
            clear_cnt <= '0;
            dir_idx   <= 2'd0;
          end else if (tick) begin
            if (blink_cnt == BL_LAST) begin
              blink_q   <= ~blink_q;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_CLEAR;
          phase_q   <= PH_ALL_RED;
          blink_q   <= 1'b0;
          clear_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semafor_ctrl.sv
// tb_semafor_ctrl
// Scoreboard bench for semafor_ctrl. A tick-level reference model runs in
// the stimulus process and queues every output change it predicts together
// with the cycle it should appear in; a monitor pops and compares whenever
// the DUT outputs actually change, and also checks the tick pattern each cycle.
module tb_semafor_ctrl;
  import semafor_pkg::*;

  localparam int DIV_CYC    = 16;
  localparam int T_CLEAR    = 2;
  localparam int T_TIMEOUT  = 40;
  localparam int BLINK_HALF = 1;

  logic clk = 1'b0;
  logic rst;
  logic mod_noapte;
  logic fault;

  semafor_if sem ();

  semafor_ctrl #(
    .DIV_CYC    (DIV_CYC),
    .T_CLEAR    (T_CLEAR),
    .T_TIMEOUT  (T_TIMEOUT),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mod_noapte (mod_noapte),
    .bus        (sem.master),
    .fault      (fault)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] code;
    logic       blink;
    logic       flt;
    int         when;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: current phase code, ticks spent in it, index of
  // the next green in the fixed order, and the latched fault.
  int         m_code;
  int         m_elapsed;
  int         m_next;
  int         m_fault;
  logic [4:0] m_prev_out;
  int         green_order[4] = '{1, 2, 3, 4};

  // Cycle index since the last reset release; the tick falls on index
  // DIV_CYC-1 of every period.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    else
      passes++;
  endtask

  function automatic logic [4:0] modelOut();
    logic blink;
    blink = (m_code == 7) && (((m_elapsed / BLINK_HALF) % 2) == 0);
    return {3'(m_code), blink, m_fault[0]};
  endfunction

  // One tick of the intersection rules, evaluated at a tick cycle.
  task automatic modelStep(input logic [3:0] rdy, input logic mod);
    int d;
    if (m_code == 7) begin
      if (!mod && m_fault == 0) begin
        m_code = 0; m_elapsed = 0; m_next = 0;
      end else begin
        m_elapsed++;
      end
    end else if (m_code == 0) begin
      if (mod) begin
        m_code = 7; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == T_CLEAR) begin
          m_code = green_order[m_next]; m_elapsed = 0;
        end
      end
    end else begin
      d = m_code - 1;
      if (rdy[d]) begin
        m_next    = (m_next + 1) % 4;
        m_code    = mod ? 7 : 0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == T_TIMEOUT) begin
          m_code = 7; m_elapsed = 0; m_fault = 1;
        end
      end
    end
  endtask

  // Drive one tick cycle: inputs are set at the negedge of the tick cycle,
  // the model advances, and any predicted change is queued for the next cycle.
  task automatic applyStimulus(input logic [3:0] rdy, input logic mod);
    logic [4:0] now_out;
    do @(negedge clk); while ((cyc % DIV_CYC) != DIV_CYC - 1);
    {sem.ready_N, sem.ready_V, sem.ready_S, sem.ready_E} = rdy;
    mod_noapte = mod;
    modelStep(rdy, mod);
    now_out = modelOut();
    if (now_out != m_prev_out)
      exp_q.push_back('{code: now_out[4:2], blink: now_out[1], flt: now_out[0], when: cyc + 1});
    m_prev_out = now_out;
    @(negedge clk);
    {sem.ready_N, sem.ready_V, sem.ready_S, sem.ready_E} = 4'b0000;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must fall back at once.
  task automatic resetPulse();
    @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_stare", sem.stare_semafor, 0);
    checkOutput("rst_clk_div", sem.clk_div, 1);
    checkOutput("rst_clk_div_int", sem.clk_div_int, 0);
    checkOutput("rst_fault", fault, 0);
    {sem.ready_N, sem.ready_V, sem.ready_S, sem.ready_E} = 4'b0000;
    mod_noapte = 1'b0;
    m_code = 0; m_elapsed = 0; m_next = 0; m_fault = 0;
    m_prev_out = 5'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Step ticks, finishing other greens early, until the model shows target.
  task automatic runUntilGreen(input int target);
    int guard = 0;
    logic [3:0] rdy;
    while (m_code != target && guard < 200) begin
      rdy = (m_code >= 1 && m_code <= 4 && m_elapsed >= 1) ? 4'(1 << (m_code - 1)) : 4'b0000;
      applyStimulus(rdy, 1'b0);
      guard++;
    end
    checkOutput("reach_green", m_code, target);
  endtask

  // Monitor: tick pattern every cycle, and one scoreboard pop per output change.
  logic [4:0] mon_cur;
  logic [4:0] mon_last = 5'b0;
  exp_t       mon_e;

  always @(negedge clk) begin
    mon_cur = {sem.stare_semafor, sem.clk_div_int, fault};
    if (rst) begin
      mon_last = mon_cur;
    end else begin
      checkOutput("clk_div", sem.clk_div, (cyc % DIV_CYC) != DIV_CYC - 1);
      if (mon_cur !== mon_last) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_change", mon_cur, mon_last);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("stare_semafor", sem.stare_semafor, mon_e.code);
          checkOutput("clk_div_int", sem.clk_div_int, mon_e.blink);
          checkOutput("fault", fault, mon_e.flt);
          checkOutput("change_cycle", cyc, mon_e.when);
        end
        mon_last = mon_cur;
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence.
  initial begin
    logic rmod;
    logic [3:0] rdy;
    rst = 1'b1;
    mod_noapte = 1'b0;
    {sem.ready_N, sem.ready_V, sem.ready_S, sem.ready_E} = 4'b0000;
    resetPulse();

    // Normal rotation: ready 5 ticks into every green, nine greens.
    for (int t = 0; t < 2 + 7 * 9; t++) begin
      rdy = (m_code >= 1 && m_code <= 4 && m_elapsed == 4) ? 4'(1 << (m_code - 1)) : 4'b0000;
      applyStimulus(rdy, 1'b0);
    end

    // Foreign readies ignored, then own ready on the watchdog's last tick.
    runUntilGreen(1);
    applyStimulus(4'b1100, 1'b0);
    applyStimulus(4'b1110, 1'b0);
    while (m_elapsed < T_TIMEOUT - 1) applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    for (int t = 0; t < 3; t++) applyStimulus(4'b0000, 1'b0);

    // Night mode requested during SUD green: no cut, then straight to flash.
    runUntilGreen(2);
    applyStimulus(4'b0000, 1'b0);
    for (int t = 0; t < 2; t++) applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0010, 1'b1);
    for (int t = 0; t < 4; t++) applyStimulus(4'b0000, 1'b1);
    for (int t = 0; t < 4; t++) applyStimulus(4'b0000, 1'b0);

    // Reset in the middle of VEST green.
    runUntilGreen(3);
    for (int t = 0; t < 3; t++) applyStimulus(4'b0000, 1'b0);
    resetPulse();
    for (int t = 0; t < 4; t++) applyStimulus(4'b0000, 1'b0);

    // Random readies and night-mode toggles.
    rmod = 1'b0;
    for (int t = 0; t < 150; t++) begin
      rdy = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'b0000;
      if ($urandom_range(19) == 0) rmod = ~rmod;
      applyStimulus(rdy, rmod);
    end

    // Watchdog expiry in EST green; fault holds flash whatever night mode does.
    resetPulse();
    runUntilGreen(1);
    for (int t = 0; t < T_TIMEOUT; t++) applyStimulus(4'b0000, 1'b0);
    for (int t = 0; t < 12; t++) applyStimulus(4'($urandom_range(15)), 1'($urandom_range(1)));

    repeat (3) @(negedge clk);
    checkOutput("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
